// File: rtl/psp_mem_pkg.sv
// Shared types and constants for the I/D memory port arbiter.
package psp_mem_pkg;

  // Which requester owns an in-flight memory read.
  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_I,
    OWN_D
  } mem_owner_t;

  // All four byte lanes enabled, as used by instruction fetches.
  localparam logic [3:0] BE_WORD = 4'b1111;

endpackage

// File: rtl/mem_resp_pipe.sv
// Delay line of owner tags that lines up each granted read with its
// returning memory data DEPTH cycles later.
module mem_resp_pipe
  import psp_mem_pkg::*;
#(
  parameter int unsigned DEPTH = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  mem_owner_t tag_in,
  output mem_owner_t tag_out
);

  mem_owner_t stages [DEPTH];

  // Shift tags one stage per cycle; reset drops anything in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        stages[i] <= OWN_NONE;
      end
    end else begin
      stages[0] <= tag_in;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        stages[i] <= stages[i-1];
      end
    end
  end

  assign tag_out = stages[DEPTH-1];

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the core fetch (I) and load/store (D) ports onto one
// single-ported synchronous memory and steers read data back to the owner.
module mem_port_arbiter
  import psp_mem_pkg::*;
#(
  parameter int unsigned MEM_LATENCY  = 1,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_gnt,
  output logic        i_rvalid,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [3:0]  d_be,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic [31:0] m_addr,
  output logic        m_we,
  output logic [3:0]  m_be,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata
);

  localparam int unsigned CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT_C = CW'(STARVE_LIMIT);

  logic [CW-1:0] starve_cnt;
  logic          starve_hit;
  mem_owner_t    tag_in;
  mem_owner_t    tag_out;

  // Grant: D has priority unless I has lost STARVE_LIMIT cycles in a row.
  always_comb begin
    starve_hit = (starve_cnt == LIMIT_C);
    i_gnt      = 1'b0;
    d_gnt      = 1'b0;
    if (!reset) begin
      if (i_req && (!d_req || starve_hit)) begin
        i_gnt = 1'b1;
      end else if (d_req) begin
        d_gnt = 1'b1;
      end
    end
  end

  // Count consecutive cycles where I asked and lost; any win or idle clears it.
  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (i_req && !i_gnt) begin
      if (starve_cnt != '1) begin
        starve_cnt <= starve_cnt + 1'b1;
      end
    end else begin
      starve_cnt <= '0;
    end
  end

  // Drive the winner onto the memory and tag reads for the response pipe.
  always_comb begin
    m_addr  = i_addr;
    m_we    = 1'b0;
    m_be    = '0;
    m_wdata = '0;
    tag_in  = OWN_NONE;
    if (i_gnt) begin
      m_be   = BE_WORD;
      tag_in = OWN_I;
    end else if (d_gnt) begin
      m_addr  = d_addr;
      m_we    = d_we;
      m_be    = d_be;
      m_wdata = d_wdata;
      if (!d_we) begin
        tag_in = OWN_D;
      end
    end
  end

  mem_resp_pipe #(
    .DEPTH (MEM_LATENCY)
  ) u_resp_pipe (
    .clk     (clk),
    .reset   (reset),
    .tag_in  (tag_in),
    .tag_out (tag_out)
  );

  // Gating with reset also drops a response whose tag left the pipe
  // in the same cycle reset was raised.
  assign i_rvalid = !reset && (tag_out == OWN_I);
  assign d_rvalid = !reset && (tag_out == OWN_D);
  assign i_rdata  = m_rdata;
  assign d_rdata  = m_rdata;

endmodule
